// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle MEM-stage data memory responder.
package dmem_pkg;
  localparam logic [31:0] DMEM_MMIO_ADDR = 32'h4000_0000;
  localparam int unsigned LATENCY_MIN    = 1;
  localparam int unsigned LATENCY_MAX    = 15;
  localparam int unsigned CNT_W          = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    RESP = ST_RESP
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } dmem_req_t;

  // Misaligned, or beyond the word array.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth_log2);
    logic [31:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data memory handshake; the MEM stage is the master.
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        mem_stall;
  logic        mem_ready;
  logic        addr_error;
  logic [31:0] mmio_out;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data, mem_stall, mem_ready, addr_error, mmio_out
  );
  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data, mem_stall, mem_ready, addr_error, mmio_out
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: synchronous write, registered read (array or external value), cleared on reset.
module dmem_array #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic                  ext_re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [31:0]           ext_data,
  output logic [31:0]           rdata
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  // Error/MMIO reads land in the same register so Read_data has a single source.
  always_comb begin
    rdata_d = rdata_q;
    if (re)          rdata_d = mem_q[addr];
    else if (ext_re) rdata_d = ext_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: stalls the pipeline LATENCY cycles, then pulses mem_ready.
// Optional MMIO register enabled by defining DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] MMIO_ADDR  = DMEM_MMIO_ADDR
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                                (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_INIT = (LAT > 1) ? CNT_W'(LAT - 2) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d, cmt;
  logic             ready_q, ready_d, err_q, err_d;
  logic [31:0]      mmio_q;
  logic             req, stall, commit, mmio_hit, bad;
  logic             arr_we, arr_re, ext_re;
  logic [31:0]      rdata;

  assign req = bus.MemRead | bus.MemWrite;

  // cmt is the request being committed this cycle: live inputs when LAT=1, else the capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cmt     = req_q;
    commit  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          req_d.wr   = bus.MemWrite;
          req_d.addr = bus.Address;
          req_d.data = bus.Write_data;
          cmt        = req_d;
          if (LAT <= 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_d;
  assign mmio_hit = (cmt.addr == MMIO_ADDR);
  assign mmio_d   = (commit && cmt.wr && mmio_hit) ? cmt.data : mmio_q;
  always_ff @(posedge clk) begin
    if (reset) mmio_q <= '0;
    else       mmio_q <= mmio_d;
  end
`else
  // MMIO_ADDR then falls through to the range check and reports addr_error.
  assign mmio_hit = 1'b0;
  assign mmio_q   = '0;
`endif

  assign bad     = !mmio_hit && addr_bad(cmt.addr, DEPTH_LOG2);
  assign arr_we  = commit &&  cmt.wr && !bad && !mmio_hit;
  assign arr_re  = commit && !cmt.wr && !bad && !mmio_hit;
  assign ext_re  = commit && !cmt.wr && (bad || mmio_hit);
  assign ready_d = commit;
  assign err_d   = commit && bad;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk      (clk),
    .reset    (reset),
    .we       (arr_we),
    .re       (arr_re),
    .ext_re   (ext_re),
    .addr     (cmt.addr[DEPTH_LOG2+1:2]),
    .wdata    (cmt.data),
    .ext_data (mmio_hit ? mmio_q : 32'd0),
    .rdata    (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_stall  = stall;
  assign bus.mem_ready  = ready_q;
  assign bus.addr_error = err_q;
  assign bus.Read_data  = rdata;
  assign bus.mmio_out   = mmio_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder (LATENCY=2 and LATENCY=1 instances) against a word-level model.
module tb_dmem_responder;
  localparam logic [31:0] MMIO = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, sel;
  logic [31:0] Address, Write_data;
  logic        stall_s, rdy_s, err_s;
  logic [31:0] rdata_s, mmio_s;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] mem_m [256];
  logic [31:0] rdata_m, mmio_m;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();

  // sel picks which instance sees requests; the other stays idle.
  assign b0.MemRead    = MemRead  & ~sel;
  assign b0.MemWrite   = MemWrite & ~sel;
  assign b0.Address    = Address;
  assign b0.Write_data = Write_data;
  assign b1.MemRead    = MemRead  & sel;
  assign b1.MemWrite   = MemWrite & sel;
  assign b1.Address    = Address;
  assign b1.Write_data = Write_data;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2), .MMIO_ADDR(MMIO)) u_lat2 (
    .clk(clk), .reset(reset), .bus(b0));
  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .MMIO_ADDR(MMIO)) u_lat1 (
    .clk(clk), .reset(reset), .bus(b1));

  assign stall_s = sel ? b1.mem_stall  : b0.mem_stall;
  assign rdy_s   = sel ? b1.mem_ready  : b0.mem_ready;
  assign err_s   = sel ? b1.addr_error : b0.addr_error;
  assign rdata_s = sel ? b1.Read_data  : b0.Read_data;
  assign mmio_s  = sel ? b1.mmio_out   : b0.mmio_out;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a == MMIO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (!is_mmio(a) && a >= 32'd1024);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    rdata_m = '0;
    mmio_m  = '0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_s}, 32'd0);
    chk({tag, "_ready"}, {31'd0, rdy_s},   32'd0);
    chk({tag, "_err"},   {31'd0, err_s},   32'd0);
    chk({tag, "_rdata"}, rdata_s,          32'd0);
    chk({tag, "_mmio"},  mmio_s,           32'd0);
  endtask

  // Entered just after a negedge with no request pending; leaves in the same position.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit flush);
    int lat    = sel ? 1 : 2;
    int stalls = 0;
    int errs   = 0;
    bit got    = 0;
    bit bad    = is_bad(a);
    bit mm     = is_mmio(a);
    MemWrite   = w;
    MemRead    = r;
    Address    = a;
    Write_data = d;
    if (w) begin
      if (mm)        mmio_m = d;
      else if (!bad) mem_m[a / 4] = d;
    end else begin
      rdata_m = bad ? 32'd0 : mm ? mmio_m : mem_m[a / 4];
    end
    for (int c = 0; c < 32; c++) begin
      #1;
      if (rdy_s) begin
        got = 1;
        errs += int'(err_s);
        chk("resp_stall", {31'd0, stall_s}, 32'd0);
        break;
      end
      stalls += int'(stall_s);
      errs   += int'(err_s);
      @(negedge clk);
      if (flush) begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = $urandom;
        Write_data = $urandom;
      end
    end
    chk("ready_seen",   {31'd0, got}, 32'd1);
    chk("stall_cycles", stalls,       lat);
    chk("addr_error",   errs,         {31'd0, bad});
    chk("read_data",    rdata_s,      rdata_m);
    chk("mmio_out",     mmio_s,       mmio_m);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_pulse", {31'd0, rdy_s},   32'd0);
    chk("idle_stall",  {31'd0, stall_s}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    sel = 1'b1; reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_zero("reset");

    // LATENCY=1 instance: writes then back-to-back reads
    access(1, 0, 32'h0, 32'd1, 0);
    access(1, 0, 32'h4, 32'd2, 0);
    access(0, 1, 32'h0, 32'd0, 0);
    access(0, 1, 32'h4, 32'd0, 0);
    access(0, 1, 32'h13, 32'd0, 0);

    // LATENCY=2 instance, untouched since reset
    sel = 1'b0;
    model_reset();
    access(1, 0, 32'h10, 32'hDEAD_BEEF, 0);
    access(0, 1, 32'h10, 32'd0, 0);
    access(0, 1, 32'h13, 32'd0, 0);
    access(0, 1, 32'h10, 32'd0, 0);
    access(1, 0, 32'h400, 32'h1234_5678, 0);
    access(0, 1, 32'h0, 32'd0, 0);
    access(1, 0, MMIO, 32'h0000_00A5, 0);
    access(0, 1, MMIO, 32'd0, 0);
    access(1, 1, 32'h8, 32'h0000_CAFE, 0);
    access(0, 1, 32'h8, 32'd0, 0);
    access(1, 0, 32'h14, 32'h77, 1);
    access(0, 1, 32'h14, 32'd0, 1);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1, 2: a = 32'($urandom_range(0, 15)) * 4;
        3:       a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
        4:       a = ($urandom | 32'h400) & ~32'h3;
        default: a = MMIO;
      endcase
      k = $urandom_range(0, 2);
      access(k != 1, k != 0, a, $urandom, $urandom_range(0, 3) == 0);
    end

    // reset during WAIT of a write: write must not land
    MemWrite = 1'b1; Address = 32'h20; Write_data = 32'h55;
    @(negedge clk);
    #1;
    chk("rst_wait_stall", {31'd0, stall_s}, 32'd1);
    reset = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_idle_zero("mid_reset");
    access(0, 1, 32'h20, 32'd0, 0);
    access(0, 1, 32'h10, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM pipeline stage.
- Services the stage's MemRead/MemWrite word requests with a parameterised multi-cycle latency.
- Drives a stall to the hazard unit until each access completes, then returns registered read data.
- Replaces the single-cycle data memory so the pipeline can tolerate slower storage.

Parameters:
- DEPTH_LOG2, 8, word-index bits; array holds 2^DEPTH_LOG2 32-bit words.
- LATENCY, 2, stall cycles per access; legal range 1..15.
- MMIO_ADDR, 32'h4000_0000, byte address of the optional MMIO register.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  read request from the MEM stage.
- MemWrite  input  1  write request from the MEM stage.
- Address  input  32  byte address; word index is Address[DEPTH_LOG2+1:2].
- Write_data  input  32  store data.
- Read_data  output  32  load data; registered.
- mem_stall  output  1  high while the request is outstanding; the pipeline holds all stages.
- mem_ready  output  1  one-cycle pulse when the access has completed.
- addr_error  output  1  one-cycle pulse when a misaligned or out-of-range access completes.
- mmio_out  output  32  MMIO register value; tied to 0 without the feature.

Behaviour:
- Interface decision: one clock, clk. reset is synchronous and active-high.
- Reset, on any clk edge with reset=1:
  - state goes to IDLE; counter is 0.
  - Read_data=0, mem_ready=0, addr_error=0, mmio_out=0.
  - All array words are cleared to 0.
  - An in-flight access is aborted and no write occurs.
- req = MemRead | MemWrite. If both are high, treat the access as a write. Writes to MMIO_ADDR update mmio_out at commit (optional feature).
- FSM states IDLE, WAIT, RESP. All outputs except mem_stall are registered.
- IDLE:
  - mem_stall = req (combinational).
  - On req, capture Address, Write_data and op.
  - LATENCY=1: go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT:
  - mem_stall=1.
  - cnt decrements each cycle; at cnt=0 go to RESP.
  - Changes on the request inputs are ignored; the captured request is committed.
- Commit, on the edge entering RESP:
  - Write: array[idx] <= captured data.
  - Read: Read_data <= array[idx]. The write-path value is not forwarded to the read in the same commit.
- RESP:
  - mem_stall=0 and mem_ready=1 for exactly one cycle; the pipeline advances on the edge ending RESP.
  - Next state is IDLE unconditionally. A back-to-back request is recognised in the following IDLE cycle.
- Stall count per access = LATENCY cycles. Total request-to-ready = LATENCY+1 cycles counting the RESP cycle.
- Read_data holds its value until the next completed read.
- Misaligned access (Address[1:0]!=0):
  - No array access; a read returns 0.
  - addr_error pulses in RESP; full latency is still spent.
- Out-of-range access (Address[31:DEPTH_LOG2+2]!=0 and not MMIO):
  - A write is dropped; a read returns 0.
  - addr_error pulses.
- A request removed during WAIT (flush) still completes; the MEM stage must discard mem_ready.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined:
  - A write to MMIO_ADDR loads mmio_out at commit, with no array write.
  - A read of MMIO_ADDR returns mmio_out.
  - No addr_error for that address.
- Undefined: mmio_out tied to 0, and MMIO_ADDR is treated as out-of-range (addr_error).

Decomposition:
- Package dmem_pkg:
  - state typedef {IDLE, WAIT, RESP}.
  - MMIO_ADDR default.
  - LATENCY range constant.
  - Helper function for range/alignment check.
- One sub-module, dmem_array:
  - 2^DEPTH_LOG2 x 32 storage.
  - Synchronous write, registered read, synchronous clear on reset.
- The FSM, counter, error logic and MMIO stay in dmem_responder.

Test Plan:
- Write then read, LATENCY=2:
  - Stimulus: MemWrite Address=0x10 Write_data=0xDEADBEEF; next request MemRead Address=0x10.
  - Required: mem_stall high for 2 cycles per access, mem_ready in the third cycle, Read_data=0xDEADBEEF.
- LATENCY=1 back-to-back reads of 0x0 and 0x4 after writes of 1 and 2 → each access stalls 1 cycle; Read_data 1 then 2; IDLE between accesses.
- Misaligned read, Address=0x13 → Read_data=0, addr_error pulses once, array unchanged.
- Out-of-range write, Address=0x400 with DEPTH_LOG2=8 → dropped, addr_error pulses; a later read of 0x0 is unchanged.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT of a write to 0x20=0x55.
  - Required: state IDLE, no stall, all outputs 0; a later read of 0x20 returns 0.
- DMEM_MMIO_EN defined:
  - Stimulus: write 0x000000A5 to 0x4000_0000, then read it back.
  - Required: mmio_out=0xA5, Read_data=0xA5, no addr_error.
  - With the macro undefined, the same write raises addr_error and mmio_out stays 0.
